// File: rtl/cs_pkg.sv
// Shared types and width helpers for the cs_window filter.
package cs_pkg;

    // Which side of the window mean the approximate value is taken from.
    typedef enum logic {
        CS_MODE_FLOOR = 1'b0,   // largest sample not above the mean
        CS_MODE_CEIL  = 1'b1    // smallest sample not below the mean
    } cs_mode_e;

    // Running-sum width: holds DEPTH full-scale samples.
    function automatic int unsigned cs_sw(input int unsigned dw, input int unsigned depth);
        return dw + $clog2(depth);
    endfunction

    // Output width after the SHIFT right-shift of (sum + DEPTH*Xappr).
    function automatic int unsigned cs_ow(input int unsigned dw, input int unsigned depth,
                                          input int unsigned shift);
        return dw + $clog2(2 * depth) - shift;
    endfunction

endpackage

// File: rtl/cs_approx_select.sv
// Picks the approximate value from a full window without dividing by DEPTH.
// A sample qualifies when Xi*DEPTH <= sum (floor) or Xi*DEPTH >= sum (ceil);
// a balanced reduction tree keeps the best qualifying candidate per node.
// Ports:
//   win     - DEPTH packed samples, entry k at [k*DW +: DW]
//   sum     - sum of all window entries
//   mode    - floor/ceil selection
//   xappr_c - selected sample (0 if nothing qualifies; cannot happen on a full window)
module cs_approx_select
    import cs_pkg::*;
#(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned DEPTH = 9,
    localparam int unsigned SW    = cs_sw(DW, DEPTH)
) (
    input  logic [DEPTH*DW-1:0] win,
    input  logic [SW-1:0]       sum,
    input  cs_mode_e            mode,
    output logic [DW-1:0]       xappr_c
);

    localparam int unsigned LV = $clog2(DEPTH);
    localparam int unsigned NL = 1 << LV;
    localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

    // Heap-ordered tree: node n has children 2n and 2n+1, leaves at NL..2NL-1.
    logic [DW-1:0] cand [2*NL];
    logic          fnd  [2*NL];
    logic [SW-1:0] prod;
    logic          lf;
    logic          rf;
    logic          better;
    logic          take_l;

    // Leaf qualification followed by pairwise reduction toward the root.
    always_comb begin
        prod   = '0;
        lf     = 1'b0;
        rf     = 1'b0;
        better = 1'b0;
        take_l = 1'b0;
        for (int i = 0; i < 2 * NL; i++) begin
            cand[i] = '0;
            fnd[i]  = 1'b0;
        end

        for (int k = 0; k < DEPTH; k++) begin
            cand[NL+k] = win[k*DW +: DW];
            prod       = SW'(win[k*DW +: DW]) * DEPTH_W;
            // Equality satisfies both modes.
            fnd[NL+k]  = (mode == CS_MODE_FLOOR) ? (prod <= sum) : (prod >= sum);
        end

        for (int n = NL - 1; n >= 1; n--) begin
            lf      = fnd[2*n];
            rf      = fnd[2*n+1];
            better  = (mode == CS_MODE_FLOOR) ? (cand[2*n] >= cand[2*n+1])
                                              : (cand[2*n] <= cand[2*n+1]);
            take_l  = lf && (!rf || better);
            fnd[n]  = lf || rf;
            cand[n] = take_l ? cand[2*n] : cand[2*n+1];
        end

        xappr_c = fnd[1] ? cand[1] : '0;
    end

endmodule

// File: rtl/cs_window.sv
// Sliding-window CS filter: keeps the last DEPTH accepted samples and a running
// sum, then produces Y = (sum + DEPTH*Xappr) >> SHIFT two edges after acceptance.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   in_valid  - X carries a sample this cycle
//   X         - unsigned sample
//   mode      - 0: floor approximation, 1: ceil approximation (captured with X)
//   flush     - synchronous window clear, wins over in_valid
//   Y         - filter result, holds while out_valid is low
//   out_valid - one-cycle pulse per new Y
//   full      - window holds DEPTH samples
module cs_window
    import cs_pkg::*;
#(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned DEPTH = 9,
    parameter  int unsigned SHIFT = 3,
    localparam int unsigned OW    = cs_ow(DW, DEPTH, SHIFT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] X,
    input  logic          mode,
    input  logic          flush,
    output logic [OW-1:0] Y,
    output logic          out_valid,
    output logic          full
);

    localparam int unsigned SW = cs_sw(DW, DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = DW + $clog2(2 * DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);
    localparam logic [TW-1:0] DEPTH_T  = TW'(DEPTH);

    logic [DW-1:0]       buf_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [CW-1:0]       fill_q;
    logic [SW-1:0]       sum_q;
    cs_mode_e            mode_q;
    logic                s1_valid_q;

    logic                accept_c;
    logic [DW-1:0]       oldest_c;
    logic [SW-1:0]       sum_nxt_c;
    logic [CW-1:0]       fill_nxt_c;
    logic [DEPTH*DW-1:0] win_c;
    logic [DW-1:0]       xappr_c;
    logic [TW-1:0]       total_c;
    logic [OW-1:0]       y_c;

    assign accept_c = in_valid & ~flush;
    // Once full, the write pointer addresses the oldest entry.
    assign oldest_c = buf_q[wr_ptr_q];

    // Incremental sum/fill update for an accepted sample.
    always_comb begin
        sum_nxt_c  = sum_q + SW'(X);
        fill_nxt_c = fill_q;
        if (fill_q == FILL_MAX) begin
            sum_nxt_c = sum_q + SW'(X) - SW'(oldest_c);
        end else begin
            fill_nxt_c = fill_q + CW'(1);
        end
    end

    // Sample storage; contents are only consulted once fully rewritten.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            buf_q[wr_ptr_q] <= X;
        end
    end

    // Stage 1: pointer, fill, running sum, mode capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            sum_q      <= '0;
            mode_q     <= CS_MODE_FLOOR;
            s1_valid_q <= 1'b0;
            full       <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            sum_q      <= '0;
            s1_valid_q <= 1'b0;
            full       <= 1'b0;
        end else if (accept_c) begin
            wr_ptr_q   <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            fill_q     <= fill_nxt_c;
            sum_q      <= sum_nxt_c;
            mode_q     <= cs_mode_e'(mode);
            s1_valid_q <= (fill_nxt_c == FILL_MAX);
            full       <= (fill_nxt_c == FILL_MAX);
        end else begin
            s1_valid_q <= 1'b0;
        end
    end

    // Present the buffer to the selector as one packed vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_pack
        assign win_c[k*DW +: DW] = buf_q[k];
    end

    cs_approx_select #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_approx_select (
        .win     (win_c),
        .sum     (sum_q),
        .mode    (mode_q),
        .xappr_c (xappr_c)
    );

    // TW bits hold DEPTH*(2^DW-1) twice over, so the shift never saturates.
    assign total_c = TW'(sum_q) + TW'(xappr_c) * DEPTH_T;
    assign y_c     = OW'(total_c >> SHIFT);

    // Stage 2: result register; a flush drops the pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid_q & ~flush;
            if (s1_valid_q && !flush) begin
                Y <= y_c;
            end
        end
    end

endmodule

// File: tb/tb_cs_window.sv
// Directed bench for cs_window at default parameters (DW=8, DEPTH=9, SHIFT=3).
module tb_cs_window;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] X;
    logic       mode;
    logic       flush;
    logic [9:0] Y;
    logic       out_valid;
    logic       full;

    int total;
    int bad;
    int ov_cnt;

    cs_window dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .X         (X),
        .mode      (mode),
        .flush     (flush),
        .Y         (Y),
        .out_valid (out_valid),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic push(input logic [7:0] x, input logic m);
        in_valid = 1'b1;
        X        = x;
        mode     = m;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic restart();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (Y !== 10'h000) begin bad++; $display("FAIL reset_y: got %0h want 0", Y); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov: got %0b want 0", out_valid); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", full); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_floor();
        logic [7:0] v [9];
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10};
        restart();
        ov_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            push(v[i], 1'b0);
            if (out_valid === 1'b1) ov_cnt++;
            if (i == 7) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL floor_full8: got %0b want 0", full); end
            end
        end
        total++; if (ov_cnt != 0) begin bad++; $display("FAIL floor_early_ov: got %0d want 0", ov_cnt); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL floor_full9: got %0b want 1", full); end
        idle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL floor_ov: got %0b want 1", out_valid); end
        total++; if (Y !== 10'h00B) begin bad++; $display("FAIL floor_y: got %0h want 00b", Y); end
        // Same window, mode switched on the second sample only.
        push(8'd1, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL floor_gap_ov: got %0b want 0", out_valid); end
        push(8'd2, 1'b1);
        total++; if (Y !== 10'h00B || out_valid !== 1'b1) begin bad++; $display("FAIL mode_keep: got %0h/%0b want 00b/1", Y, out_valid); end
        idle();
        total++; if (Y !== 10'h00C || out_valid !== 1'b1) begin bad++; $display("FAIL mode_switch: got %0h/%0b want 00c/1", Y, out_valid); end
    endtask

    task automatic test_ceil();
        logic [7:0] v [9];
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10};
        restart();
        for (int i = 0; i < 9; i++) push(v[i], 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ceil_early_ov: got %0b want 0", out_valid); end
        push(8'd100, 1'b1);
        total++; if (Y !== 10'h00C || out_valid !== 1'b1) begin bad++; $display("FAIL ceil_y: got %0h/%0b want 00c/1", Y, out_valid); end
        idle();
        total++; if (Y !== 10'h082 || out_valid !== 1'b1) begin bad++; $display("FAIL ceil_b2b: got %0h/%0b want 082/1", Y, out_valid); end
        idle();
        total++; if (Y !== 10'h082 || out_valid !== 1'b0) begin bad++; $display("FAIL ceil_hold: got %0h/%0b want 082/0", Y, out_valid); end
    endtask

    task automatic test_extremes();
        restart();
        for (int i = 0; i < 9; i++) push(8'hFF, 1'b0);
        idle();
        total++; if (Y !== 10'h23D || out_valid !== 1'b1) begin bad++; $display("FAIL max_y: got %0h/%0b want 23d/1", Y, out_valid); end
        restart();
        for (int i = 0; i < 9; i++) push(8'd7, 1'b0);
        idle();
        total++; if (Y !== 10'h00F || out_valid !== 1'b1) begin bad++; $display("FAIL tie_floor: got %0h/%0b want 00f/1", Y, out_valid); end
        push(8'd7, 1'b1);
        idle();
        total++; if (Y !== 10'h00F || out_valid !== 1'b1) begin bad++; $display("FAIL tie_ceil: got %0h/%0b want 00f/1", Y, out_valid); end
    endtask

    task automatic test_gaps();
        logic [7:0] s [3];
        logic [9:0] e [3];
        s = '{8'd100, 8'd0, 8'd50};
        e = '{10'h01C, 10'h01B, 10'h021};
        restart();
        for (int i = 1; i <= 9; i++) push(8'(i), 1'b0);
        idle();
        total++; if (Y !== 10'h00B || out_valid !== 1'b1) begin bad++; $display("FAIL gap_first: got %0h/%0b want 00b/1", Y, out_valid); end
        for (int j = 0; j < 3; j++) begin
            ov_cnt = 0;
            push(s[j], 1'b0);
            if (out_valid === 1'b1) ov_cnt++;
            for (int g = 0; g < 3; g++) begin
                idle();
                if (out_valid === 1'b1) ov_cnt++;
                total++; if (Y !== e[j]) begin bad++; $display("FAIL gap_y[%0d.%0d]: got %0h want %0h", j, g, Y, e[j]); end
            end
            total++; if (ov_cnt != 1) begin bad++; $display("FAIL gap_pulses[%0d]: got %0d want 1", j, ov_cnt); end
        end
    endtask

    task automatic test_flush();
        restart();
        for (int i = 1; i <= 9; i++) push(8'(i), 1'b0);
        repeat (2) idle();
        flush    = 1'b1;
        in_valid = 1'b1;
        X        = 8'd200;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (full !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_full: got %0b/%0b want 0/0", full, out_valid); end
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            push(8'd4, 1'b0);
            if (out_valid === 1'b1) ov_cnt++;
        end
        idle();
        if (out_valid === 1'b1) ov_cnt++;
        total++; if (ov_cnt != 0 || full !== 1'b0) begin bad++; $display("FAIL flush_refill: got %0d/%0b want 0/0", ov_cnt, full); end
        push(8'd4, 1'b0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL flush_full9: got %0b want 1", full); end
        idle();
        total++; if (Y !== 10'h009 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_y: got %0h/%0b want 009/1", Y, out_valid); end
    endtask

    task automatic test_async_reset();
        restart();
        for (int i = 0; i < 9; i++) push(8'hFF, 1'b0);
        idle();
        total++; if (Y !== 10'h23D || out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre: got %0h/%0b want 23d/1", Y, out_valid); end
        #2 reset = 1'b0;
        #1;
        total++; if (Y !== 10'h000 || out_valid !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL areset_now: got %0h/%0b/%0b want 0/0/0", Y, out_valid, full); end
        @(negedge clk);
        reset = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            push(8'd2, 1'b0);
            if (out_valid === 1'b1) ov_cnt++;
        end
        total++; if (ov_cnt != 0 || full !== 1'b0) begin bad++; $display("FAIL areset_refill: got %0d/%0b want 0/0", ov_cnt, full); end
        push(8'd2, 1'b0);
        idle();
        total++; if (Y !== 10'h004 || out_valid !== 1'b1) begin bad++; $display("FAIL areset_y: got %0h/%0b want 004/1", Y, out_valid); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        ov_cnt   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        X        = '0;
        mode     = 1'b0;
        flush    = 1'b0;
        test_reset();
        test_floor();
        test_ceil();
        test_extremes();
        test_gaps();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
